sha2_compress_engine: RTL and testbench
=======================================

Name: sha2_compress_engine

Overview:
Parametrised SHA-2 compression engine; the successor to the single-width, free-running compressor.
- Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).
- Configurable round unrolling; START/BUSY/DONE handshake; W_VALID stall; synchronous abort.
- Applies the feed-forward addition internally and outputs the final chaining value (digest) directly.
- Sits between the message-schedule/K-constant supplier and the multi-block padding/controller logic.

Parameters:
- WORD_W, 32, word width; 32 selects SHA-256, 64 selects SHA-512.
- ROUNDS, 64, round count; must be 64 when WORD_W=32 and 80 when WORD_W=64.
- UNROLL, 1, rounds applied per clock; legal values 1, 2, 4; must divide ROUNDS.
- IDX_W (localparam), $clog2(ROUNDS), round-index width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  begin compression of one block; sampled only in IDLE.
- ABORT  in  1  synchronous abort to IDLE.
- H_IN  in  8*WORD_W  input chaining value; H0 in the MSBs.
- W_VALID  in  1  W_IN/K_IN are valid for the current RND_IDX.
- W_IN  in  UNROLL*WORD_W  schedule words for rounds RND_IDX..RND_IDX+UNROLL-1; slice j at [j*WORD_W +: WORD_W].
- K_IN  in  UNROLL*WORD_W  round constants, sliced the same way as W_IN.
- RND_IDX  out  IDX_W  index of the first round in the current group.
- BUSY  out  1  high in RUN and FINAL.
- DONE  out  1  one-cycle pulse; DIGEST is valid.
- DIGEST  out  8*WORD_W  H_IN + final working variables, per word mod 2^WORD_W.

Behaviour:
- Reset (RESET_N=0, asynchronous, also mid-operation): state=IDLE; all H and working-variable registers 0; RND_IDX=0; BUSY=0; DONE=0; DIGEST=0.
- States:
  - IDLE:
    - START=1 → latch H_IN into the H registers and into a..h.
    - Set RND_IDX=0 and go to RUN.
  - RUN:
    - W_VALID=1 → apply UNROLL chained rounds, using slice j for round RND_IDX+j; RND_IDX += UNROLL.
    - If that group contained round ROUNDS-1 → FINAL.
    - W_VALID=0 → hold all state, including RND_IDX.
  - FINAL: DIGEST_i <= H_i + var_i; DONE <= 1; go to IDLE with RND_IDX=0.
- DONE is registered and high for exactly one cycle.
- Latency, with W_VALID held high and N=ROUNDS/UNROLL:
  - START sampled at edge 0; DONE high between edges N+1 and N+2.
  - SHA-256 with UNROLL=1: DONE rises 65 clocks after the START edge.
- Back-to-back blocks:
  - START during the DONE cycle is accepted (state is IDLE).
  - The controller feeds the previous DIGEST back on H_IN.
- START while BUSY is ignored; no queueing.
- ABORT has priority over START and W_VALID in every state:
  - → IDLE, RND_IDX=0, no DONE pulse.
  - DIGEST keeps its previous value.
- DIGEST changes only in FINAL and on reset.
- Round function (per round):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K + W; T2 = Σ0(a) + Maj(a,b,c).
  - a..h ← T1+T2, a, b, c, d+T1, e, f, g.
  - All additions mod 2^WORD_W; carries are discarded.
- Rotation amounts (ROTR):
  - WORD_W=32: Σ0 = (2,13,22), Σ1 = (6,11,25).
  - WORD_W=64: Σ0 = (28,34,39), Σ1 = (14,18,41).
- Illegal parameter combinations are rejected at elaboration with a fatal error.

Decomposition:
- Package sha2_pkg holds:
  - state enum (IDLE, RUN, FINAL);
  - Σ rotation-amount constants per width;
  - SHA-256/SHA-512 IV constants for benches and controllers;
  - a legal-parameter check function.
- Sub-module sha2_round: combinational single round, parametrised by WORD_W. The engine instantiates it UNROLL times in a chain via generate.
- K tables are not inside this block; they are supplied externally through K_IN.

Test Plan:
- SHA-256, "abc" padded block, IV on H_IN, W_VALID=1 → DONE 65 clocks after START; DIGEST = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- SHA-256 empty message, UNROLL=4 → DONE at 17 clocks; DIGEST = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- SHA-512 "abc", UNROLL=1 → DONE at 81 clocks; DIGEST = ddaf35a193617aba cc417349ae204131 12e6fa4e89a97ea2 0a9eeee64b55d39a 2192992a274fc1a8 36ba3c23a3feebbd 454d4423643ce80e 2a9ac94fa54ca49f.
- SHA-256 "abc" with W_VALID randomly low 30% of cycles → same digest as the first test; RND_IDX never skips; DONE delay equals 65 plus the stalled cycles.
- ABORT at RND_IDX=20, then a new START with "abc" → no DONE for the aborted run; DIGEST holds its prior value until the second run's correct DONE.
- RESET_N pulsed low at RND_IDX=40 → immediately BUSY=0, DIGEST=0, RND_IDX=0; START during BUSY is ignored (RND_IDX continues unperturbed).

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 compression engine.
//   - sha2_state_e   : engine FSM states
//   - Sigma rotation amounts for the 32-bit (SHA-256) and 64-bit (SHA-512) round functions
//   - SHA-256 / SHA-512 initial hash values, for controllers and benches
//   - params_legal() : elaboration-time check of the WORD_W / ROUNDS / UNROLL combination
package sha2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinal
    } sha2_state_e;

    // Big-sigma rotation amounts, SHA-256.
    localparam int unsigned Sha256Sigma0R1 = 2;
    localparam int unsigned Sha256Sigma0R2 = 13;
    localparam int unsigned Sha256Sigma0R3 = 22;
    localparam int unsigned Sha256Sigma1R1 = 6;
    localparam int unsigned Sha256Sigma1R2 = 11;
    localparam int unsigned Sha256Sigma1R3 = 25;

    // Big-sigma rotation amounts, SHA-512.
    localparam int unsigned Sha512Sigma0R1 = 28;
    localparam int unsigned Sha512Sigma0R2 = 34;
    localparam int unsigned Sha512Sigma0R3 = 39;
    localparam int unsigned Sha512Sigma1R1 = 14;
    localparam int unsigned Sha512Sigma1R2 = 18;
    localparam int unsigned Sha512Sigma1R3 = 41;

    // Initial hash values, H0 in the MSBs.
    localparam logic [255:0] Sha256Iv = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [511:0] Sha512Iv = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // Width/round pairing is fixed by the algorithm; the unroll factor must tile the rounds.
    function automatic bit params_legal(input int unsigned word_w, input int unsigned rounds,
                                        input int unsigned unroll);
        bit width_ok;
        bit unroll_ok;
        width_ok  = ((word_w == 32) && (rounds == 64)) || ((word_w == 64) && (rounds == 80));
        unroll_ok = (unroll == 1) || (unroll == 2) || (unroll == 4);
        return width_ok && unroll_ok && ((rounds % unroll) == 0);
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round.
//   vars_i : working variables {a,b,c,d,e,f,g,h}, a in the MSBs
//   k_i    : round constant
//   w_i    : message-schedule word
//   vars_o : working variables after the round, same packing as vars_i
module sha2_round
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [8*WORD_W-1:0] vars_i,
    input  logic [WORD_W-1:0]   k_i,
    input  logic [WORD_W-1:0]   w_i,
    output logic [8*WORD_W-1:0] vars_o
);

    localparam bit Wide = (WORD_W == 64);

    localparam int unsigned S0R1 = Wide ? Sha512Sigma0R1 : Sha256Sigma0R1;
    localparam int unsigned S0R2 = Wide ? Sha512Sigma0R2 : Sha256Sigma0R2;
    localparam int unsigned S0R3 = Wide ? Sha512Sigma0R3 : Sha256Sigma0R3;
    localparam int unsigned S1R1 = Wide ? Sha512Sigma1R1 : Sha256Sigma1R1;
    localparam int unsigned S1R2 = Wide ? Sha512Sigma1R2 : Sha256Sigma1R2;
    localparam int unsigned S1R3 = Wide ? Sha512Sigma1R3 : Sha256Sigma1R3;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] sum0, sum1, ch, maj, t1, t2;

    assign {a, b, c, d, e, f, g, h} = vars_i;

    assign sum0 = rotr(a, S0R1) ^ rotr(a, S0R2) ^ rotr(a, S0R3);
    assign sum1 = rotr(e, S1R1) ^ rotr(e, S1R2) ^ rotr(e, S1R3);
    assign ch   = (e & f) ^ (~e & g);
    assign maj  = (a & b) ^ (a & c) ^ (b & c);

    // All sums wrap at the word width.
    assign t1 = h + sum1 + ch + k_i + w_i;
    assign t2 = sum0 + maj;

    assign vars_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_compress_engine.sv
// SHA-2 compression engine (SHA-256 or SHA-512) with configurable round unrolling.
// Compresses one block per START and applies the feed-forward addition internally.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   START        : begin a block (sampled only in IDLE)
//   ABORT        : synchronous return to IDLE, highest priority, no DONE
//   H_IN         : input chaining value, H0 in the MSBs
//   W_VALID      : W_IN/K_IN hold the words for rounds RND_IDX..RND_IDX+UNROLL-1
//   W_IN, K_IN   : schedule words / round constants, slice j = round RND_IDX+j
//   RND_IDX      : first round of the group currently requested
//   BUSY         : high in RUN and FINAL
//   DONE         : one-cycle pulse, DIGEST valid
//   DIGEST       : H_IN + final working variables, per word
module sha2_compress_engine
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned UNROLL = 1,
    localparam int unsigned IDX_W = $clog2(ROUNDS)
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [8*WORD_W-1:0]      H_IN,
    input  logic                     W_VALID,
    input  logic [UNROLL*WORD_W-1:0] W_IN,
    input  logic [UNROLL*WORD_W-1:0] K_IN,
    output logic [IDX_W-1:0]         RND_IDX,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [8*WORD_W-1:0]      DIGEST
);

    localparam int unsigned   STATE_W   = 8 * WORD_W;
    localparam logic [IDX_W-1:0] LastGroup = IDX_W'(ROUNDS - UNROLL);
    localparam logic [IDX_W-1:0] Step      = IDX_W'(UNROLL);

    if (!params_legal(WORD_W, ROUNDS, UNROLL)) begin : g_param_check
        $fatal(1, "sha2_compress_engine: illegal WORD_W/ROUNDS/UNROLL combination");
    end

    sha2_state_e        state_q;
    logic [STATE_W-1:0] h_q;
    logic [STATE_W-1:0] vars_q;
    logic [STATE_W-1:0] digest_q;
    logic [IDX_W-1:0]   rnd_idx_q;
    logic               busy_q;
    logic               done_q;

    logic [STATE_W-1:0] round_out;
    logic [STATE_W-1:0] feed_fwd;

    // Chain of UNROLL rounds; stage j consumes slice j of W_IN/K_IN.
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        logic [STATE_W-1:0] vars_in;
        logic [STATE_W-1:0] vars_out;

        if (j == 0) begin : g_first
            assign vars_in = vars_q;
        end else begin : g_next
            assign vars_in = g_round[j-1].vars_out;
        end

        sha2_round #(
            .WORD_W (WORD_W)
        ) u_round (
            .vars_i (vars_in),
            .k_i    (K_IN[j*WORD_W +: WORD_W]),
            .w_i    (W_IN[j*WORD_W +: WORD_W]),
            .vars_o (vars_out)
        );
    end

    assign round_out = g_round[UNROLL-1].vars_out;

    for (genvar i = 0; i < 8; i++) begin : g_feed_fwd
        assign feed_fwd[i*WORD_W +: WORD_W] = h_q[i*WORD_W +: WORD_W]
                                            + vars_q[i*WORD_W +: WORD_W];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StIdle;
            h_q       <= '0;
            vars_q    <= '0;
            digest_q  <= '0;
            rnd_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ABORT) begin
                // DIGEST is deliberately left alone so the last good result survives.
                state_q   <= StIdle;
                rnd_idx_q <= '0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (START) begin
                            h_q       <= H_IN;
                            vars_q    <= H_IN;
                            rnd_idx_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= StRun;
                        end
                    end
                    StRun: begin
                        if (W_VALID) begin
                            vars_q    <= round_out;
                            rnd_idx_q <= rnd_idx_q + Step;
                            if (rnd_idx_q == LastGroup) begin
                                state_q <= StFinal;
                            end
                        end
                    end
                    StFinal: begin
                        digest_q  <= feed_fwd;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        rnd_idx_q <= '0;
                        state_q   <= StIdle;
                    end
                    default: begin
                        state_q   <= StIdle;
                        rnd_idx_q <= '0;
                        busy_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign RND_IDX = rnd_idx_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign DIGEST  = digest_q;

endmodule

// File: tb/tb_sha2_compress_engine.sv
// Bench for sha2_compress_engine: three instances (SHA-256 x1, SHA-256 x4, SHA-512 x1) fed
// from a bench-side message schedule; table of known-answer blocks plus abort/reset sequences.
module tb_sha2_compress_engine;
    import sha2_pkg::*;

    localparam logic [255:0] DigAbc256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DigEmpty256 =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] DigAbc512 = {
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f
    };

    // SHA-512 round constants; the SHA-256 constants are their upper 32 bits.
    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef struct {
        int          sel;     // 0: SHA-256 x1, 1: SHA-256 x4, 2: SHA-512 x1
        int          blk;     // 0: "abc" 256, 1: "" 256, 2: "abc" 512
        int          stall;   // percent of cycles with W_VALID low
        bit          bstart;  // hold START high while busy, with junk on H_IN
        logic [511:0] dig;
        int          lat;     // DONE latency with no stalls
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [2:0]   start;
    logic         abort;
    logic         w_valid;
    logic [511:0] h_in;
    logic [127:0] w_in;
    logic [127:0] k_in;

    logic [5:0]   idx0, idx1;
    logic [6:0]   idx2;
    logic         busy0, busy1, busy2;
    logic         done0, done1, done2;
    logic [255:0] dig0, dig1;
    logic [511:0] dig2;

    int           sel;
    logic [6:0]   d_idx;
    logic         d_busy;
    logic         d_done;
    logic [511:0] d_digest;

    logic [63:0]  sched [80];
    logic [63:0]  kk [80];

    int n_checks;
    int n_pass;

    sha2_compress_engine #(.WORD_W(32), .ROUNDS(64), .UNROLL(1)) u_dut0 (
        .CLK(clk), .RESET_N(rst_n), .START(start[0]), .ABORT(abort), .H_IN(h_in[255:0]),
        .W_VALID(w_valid), .W_IN(w_in[31:0]), .K_IN(k_in[31:0]),
        .RND_IDX(idx0), .BUSY(busy0), .DONE(done0), .DIGEST(dig0)
    );

    sha2_compress_engine #(.WORD_W(32), .ROUNDS(64), .UNROLL(4)) u_dut1 (
        .CLK(clk), .RESET_N(rst_n), .START(start[1]), .ABORT(abort), .H_IN(h_in[255:0]),
        .W_VALID(w_valid), .W_IN(w_in[127:0]), .K_IN(k_in[127:0]),
        .RND_IDX(idx1), .BUSY(busy1), .DONE(done1), .DIGEST(dig1)
    );

    sha2_compress_engine #(.WORD_W(64), .ROUNDS(80), .UNROLL(1)) u_dut2 (
        .CLK(clk), .RESET_N(rst_n), .START(start[2]), .ABORT(abort), .H_IN(h_in),
        .W_VALID(w_valid), .W_IN(w_in[63:0]), .K_IN(k_in[63:0]),
        .RND_IDX(idx2), .BUSY(busy2), .DONE(done2), .DIGEST(dig2)
    );

    always_comb begin
        d_idx    = '0;
        d_busy   = 1'b0;
        d_done   = 1'b0;
        d_digest = '0;
        case (sel)
            0: begin
                d_idx = {1'b0, idx0}; d_busy = busy0; d_done = done0;
                d_digest = {256'b0, dig0};
            end
            1: begin
                d_idx = {1'b0, idx1}; d_busy = busy1; d_done = done1;
                d_digest = {256'b0, dig1};
            end
            default: begin
                d_idx = idx2; d_busy = busy2; d_done = done2; d_digest = dig2;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Padded single-block messages and their expanded schedule.
    task automatic build_sched(input int ww, input int blk);
        logic [31:0] s0_32, s1_32, w32;
        logic [63:0] s0_64, s1_64;
        for (int t = 0; t < 80; t++) sched[t] = '0;
        case (blk)
            0: begin sched[0] = 64'h61626380;         sched[15] = 64'h18; end
            1: begin sched[0] = 64'h80000000; end
            default: begin sched[0] = 64'h6162638000000000; sched[15] = 64'h18; end
        endcase
        for (int t = 16; t < 80; t++) begin
            if (ww == 32) begin
                s0_32 = rotr32(sched[t-15][31:0], 7) ^ rotr32(sched[t-15][31:0], 18)
                      ^ (sched[t-15][31:0] >> 3);
                s1_32 = rotr32(sched[t-2][31:0], 17) ^ rotr32(sched[t-2][31:0], 19)
                      ^ (sched[t-2][31:0] >> 10);
                w32 = s1_32 + sched[t-7][31:0] + s0_32 + sched[t-16][31:0];
                sched[t] = {32'b0, w32};
            end else begin
                s0_64 = rotr64(sched[t-15], 1) ^ rotr64(sched[t-15], 8) ^ (sched[t-15] >> 7);
                s1_64 = rotr64(sched[t-2], 19) ^ rotr64(sched[t-2], 61) ^ (sched[t-2] >> 6);
                sched[t] = s1_64 + sched[t-7] + s0_64 + sched[t-16];
            end
        end
        for (int t = 0; t < 80; t++) kk[t] = (ww == 32) ? {32'b0, K512[t][63:32]} : K512[t];
    endtask

    task automatic drive_group(input int ww, input int un, input int nr, input int e,
                               input bit valid);
        w_valid = valid;
        w_in = '0;
        k_in = '0;
        for (int j = 0; j < un; j++) begin
            if (e + j < nr) begin
                if (ww == 32) begin
                    w_in[j*32 +: 32] = sched[e+j][31:0];
                    k_in[j*32 +: 32] = kk[e+j][31:0];
                end else begin
                    w_in[j*64 +: 64] = sched[e+j];
                    k_in[j*64 +: 64] = kk[e+j];
                end
            end
        end
    endtask

    // Starts a block on instance s and feeds it; called ~1ns after a rising edge. Returns in
    // the DONE cycle, or, when stop_at >= 0, just before the group at round stop_at is fed.
    task automatic run_block(input int s, input int blk, input int stall_pct, input bit bstart,
                             input int stop_at, input logic [511:0] exp_dig, input int exp_lat);
        int ww, nr, un, e, cyc, stalls, lat, bad_at;
        bit valid;
        sel = s;
        ww  = (s == 2) ? 64 : 32;
        nr  = (s == 2) ? 80 : 64;
        un  = (s == 1) ? 4 : 1;
        build_sched(ww, blk);
        h_in     = (ww == 64) ? Sha512Iv : {256'b0, Sha256Iv};
        start[s] = 1'b1;
        w_valid  = 1'b0;
        @(posedge clk); #1;
        start[s] = bstart;
        if (bstart) h_in = {16{32'h0badf00d}};
        check("busy_after_start", d_busy, 1);
        check("idx_after_start", d_idx, 0);
        check("done_one_cycle", d_done, 0);

        e = 0; cyc = 0; stalls = 0; lat = -1; bad_at = 999; valid = 1'b1;
        while (lat < 0 && e != stop_at && cyc < 600) begin
            if (e < nr) begin
                if (bad_at == 999 && (d_idx != 7'(e) || !d_busy)) bad_at = e;
                valid = ($urandom_range(99) >= stall_pct);
                drive_group(ww, un, nr, e, valid);
            end else begin
                w_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (e < nr) begin
                if (valid) e += un;
                else stalls++;
            end
            if (d_done) lat = cyc;
        end
        start[s] = 1'b0;
        w_valid  = 1'b0;
        check("rnd_idx_first_bad_round", bad_at, 999);
        if (stop_at < 0) begin
            check("done_latency", lat, exp_lat + stalls);
            check("digest", d_digest, exp_dig);
            check("busy_after_done", d_busy, 0);
        end
    endtask

    vec_t vecs [6];
    bit   quiet;

    initial begin
        vecs[0] = '{0, 0, 0,  1'b0, {256'b0, DigAbc256},   65};
        vecs[1] = '{0, 0, 30, 1'b0, {256'b0, DigAbc256},   65};
        vecs[2] = '{1, 1, 0,  1'b0, {256'b0, DigEmpty256}, 17};
        vecs[3] = '{1, 0, 0,  1'b1, {256'b0, DigAbc256},   17};
        vecs[4] = '{2, 2, 0,  1'b0, DigAbc512,             81};
        vecs[5] = '{0, 1, 0,  1'b1, {256'b0, DigEmpty256}, 65};

        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = '0; abort = 1'b0; w_valid = 1'b0;
        h_in = '0; w_in = '0; k_in = '0; sel = 0;

        // Reset state of every instance.
        #3;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("reset_idx", d_idx, 0);
            check("reset_busy", d_busy, 0);
            check("reset_done", d_done, 0);
            check("reset_digest", d_digest, 0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer blocks; consecutive rows on one instance run back to back.
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].sel, vecs[i].blk, vecs[i].stall, vecs[i].bstart, -1,
                      vecs[i].dig, vecs[i].lat);
        end

        // Abort at round 20 with START and W_VALID also high.
        run_block(0, 0, 0, 1'b0, 20, '0, 0);
        check("abort_pre_idx", d_idx, 20);
        check("digest_hold_in_run", d_digest, {256'b0, DigEmpty256});
        drive_group(32, 1, 64, 20, 1'b1);
        abort = 1'b1; start[0] = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start[0] = 1'b0; w_valid = 1'b0;
        check("abort_busy", d_busy, 0);
        check("abort_idx", d_idx, 0);
        check("abort_done", d_done, 0);
        check("abort_digest_hold", d_digest, {256'b0, DigEmpty256});
        quiet = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (d_done || d_busy) quiet = 1'b0;
        end
        check("abort_stays_idle", quiet, 1);
        run_block(0, 0, 0, 1'b0, -1, {256'b0, DigAbc256}, 65);

        // Asynchronous reset at round 40, with START held high during the run.
        run_block(0, 0, 0, 1'b1, 40, '0, 0);
        check("reset_pre_idx", d_idx, 40);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", d_busy, 0);
        check("midrun_reset_idx", d_idx, 0);
        check("midrun_reset_digest", d_digest, 0);
        check("midrun_reset_done", d_done, 0);
        sel = 2; #1;
        check("midrun_reset_digest_512", d_digest, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(0, 0, 0, 1'b0, -1, {256'b0, DigAbc256}, 65);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
